// File: rtl/freq_sweep_ctrl.sv
// Sweep sequencer for the phase-accumulator frequency generator: steps a tuning
// word from start to stop with a programmable dwell, with loop, pause and abort.
module freq_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [WIDTH-1:0]   i_cfg_start,
  input  logic [WIDTH-1:0]   i_cfg_stop,
  input  logic [WIDTH-1:0]   i_cfg_step,
  input  logic [DWELL_W-1:0] i_cfg_dwell,
  input  logic               i_cfg_loop,
  input  logic               i_pause,
  input  logic               i_abort,
  output logic [WIDTH-1:0]   o_gen_data,
  output logic               o_gen_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_sweep_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DWELL  = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_stop;
  logic [WIDTH-1:0]   r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop;
  logic [DWELL_W-1:0] r_dcnt;
  logic               r_pend;
  logic [WIDTH-1:0]   r_gen_data;
  logic               r_gen_enable;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_sweep_cnt;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_start_nxt;
  logic [WIDTH-1:0]   w_stop_nxt;
  logic [WIDTH-1:0]   w_step_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic               w_loop_nxt;
  logic [DWELL_W-1:0] w_dcnt_nxt;
  logic               w_pend_nxt;
  logic [WIDTH-1:0]   w_gen_data_nxt;
  logic               w_gen_enable_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [CNT_W-1:0]   w_sweep_cnt_nxt;
  logic               w_do_step;

  logic               w_accept;
  logic [DWELL_W-1:0] w_dwell_m1;
  logic [WIDTH:0]     w_sum;
  logic               w_last;

  assign o_cfg_ready = ((r_state == S_IDLE) || (r_state == S_DONE)) && !i_abort && !i_rst;
  assign w_accept    = i_cfg_valid && o_cfg_ready;
  assign w_dwell_m1  = (i_cfg_dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                        : (i_cfg_dwell - DWELL_W'(1));
  // Sum kept one bit wider so an overflowing step is caught by the compare.
  assign w_sum  = {1'b0, r_gen_data} + {1'b0, r_step};
  assign w_last = (r_step == {WIDTH{1'b0}}) || (r_start > r_stop) || (w_sum > {1'b0, r_stop});

  assign o_gen_data   = r_gen_data;
  assign o_gen_enable = r_gen_enable;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sweep_cnt  = r_sweep_cnt;

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_start_nxt      = r_start;
    w_stop_nxt       = r_stop;
    w_step_nxt       = r_step;
    w_dwell_nxt      = r_dwell;
    w_loop_nxt       = r_loop;
    w_dcnt_nxt       = r_dcnt;
    w_pend_nxt       = r_pend;
    w_gen_data_nxt   = r_gen_data;
    w_gen_enable_nxt = r_gen_enable;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_sweep_cnt_nxt  = r_sweep_cnt;
    w_do_step        = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_start_nxt      = i_cfg_start;
          w_stop_nxt       = i_cfg_stop;
          w_step_nxt       = i_cfg_step;
          w_dwell_nxt      = w_dwell_m1;
          w_loop_nxt       = i_cfg_loop;
          w_dcnt_nxt       = w_dwell_m1;
          w_pend_nxt       = 1'b0;
          w_gen_data_nxt   = i_cfg_start;
          w_gen_enable_nxt = 1'b1;
          w_busy_nxt       = 1'b1;
          w_sweep_cnt_nxt  = {CNT_W{1'b0}};
          w_state_nxt      = S_DWELL;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DWELL: begin
        if (i_abort) begin
          w_state_nxt      = S_IDLE;
          w_gen_enable_nxt = 1'b0;
          w_busy_nxt       = 1'b0;
        end else if (i_pause) begin
          // The pause-entry cycle was still enabled, so it consumes dwell;
          // at expiry the step is remembered and applied on resume.
          w_state_nxt      = S_PAUSED;
          w_gen_enable_nxt = 1'b0;
          if (r_dcnt != {DWELL_W{1'b0}}) begin
            w_dcnt_nxt = r_dcnt - DWELL_W'(1);
          end else begin
            w_pend_nxt = 1'b1;
          end
        end else if (r_dcnt != {DWELL_W{1'b0}}) begin
          w_dcnt_nxt = r_dcnt - DWELL_W'(1);
        end else begin
          w_do_step = 1'b1;
        end
      end
      S_PAUSED: begin
        if (i_abort) begin
          w_state_nxt      = S_IDLE;
          w_gen_enable_nxt = 1'b0;
          w_busy_nxt       = 1'b0;
          w_pend_nxt       = 1'b0;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSED;
        end else begin
          w_state_nxt      = S_DWELL;
          w_gen_enable_nxt = 1'b1;
          if (r_pend) begin
            w_pend_nxt = 1'b0;
            w_do_step  = 1'b1;
          end else begin
            w_pend_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_gen_enable_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
      end
    endcase

    if (w_do_step) begin
      if (!w_last) begin
        w_gen_data_nxt = w_sum[WIDTH-1:0];
        w_dcnt_nxt     = r_dwell;
      end else begin
        w_sweep_cnt_nxt = r_sweep_cnt + CNT_W'(1);
        if (r_loop) begin
          w_gen_data_nxt = r_start;
          w_dcnt_nxt     = r_dwell;
        end else begin
          w_state_nxt      = S_DONE;
          w_gen_enable_nxt = 1'b0;
          w_busy_nxt       = 1'b0;
          w_done_nxt       = 1'b1;
        end
      end
    end else begin
      w_pend_nxt = w_pend_nxt;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_start      <= {WIDTH{1'b0}};
      r_stop       <= {WIDTH{1'b0}};
      r_step       <= {WIDTH{1'b0}};
      r_dwell      <= {DWELL_W{1'b0}};
      r_loop       <= 1'b0;
      r_dcnt       <= {DWELL_W{1'b0}};
      r_pend       <= 1'b0;
      r_gen_data   <= {WIDTH{1'b0}};
      r_gen_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sweep_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_start      <= w_start_nxt;
      r_stop       <= w_stop_nxt;
      r_step       <= w_step_nxt;
      r_dwell      <= w_dwell_nxt;
      r_loop       <= w_loop_nxt;
      r_dcnt       <= w_dcnt_nxt;
      r_pend       <= w_pend_nxt;
      r_gen_data   <= w_gen_data_nxt;
      r_gen_enable <= w_gen_enable_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_sweep_cnt  <= w_sweep_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed self-checking bench for freq_sweep_ctrl; inputs change and outputs
// are checked on the falling clock edge.
module tb_freq_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_start;
  logic [7:0]  cfg_stop;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_loop;
  logic        pause;
  logic        abort;
  logic [7:0]  gen_data;
  logic        gen_enable;
  logic        busy;
  logic        done;
  logic [7:0]  sweep_cnt;

  int n_checks = 0;
  int n_errors = 0;

  freq_sweep_ctrl #(.WIDTH(8), .DWELL_W(16), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_start  (cfg_start),
    .i_cfg_stop   (cfg_stop),
    .i_cfg_step   (cfg_step),
    .i_cfg_dwell  (cfg_dwell),
    .i_cfg_loop   (cfg_loop),
    .i_pause      (pause),
    .i_abort      (abort),
    .o_gen_data   (gen_data),
    .o_gen_enable (gen_enable),
    .o_busy       (busy),
    .o_done       (done),
    .o_sweep_cnt  (sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic en,
                         input logic b, input logic dn);
    chk({tag, ".data"}, {24'd0, gen_data}, {24'd0, d});
    chk({tag, ".en"}, {31'd0, gen_enable}, {31'd0, en});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
                         input logic [15:0] dw, input logic lp);
    cfg_start = s;
    cfg_stop  = e;
    cfg_step  = st;
    cfg_dwell = dw;
    cfg_loop  = lp;
    cfg_valid = 1'b1;
  endtask

  initial begin
    logic [7:0] words [4];
    logic [7:0] lseq [6];
    words = '{8'd10, 8'd20, 8'd30, 8'd40};
    lseq  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    rst = 1'b1; cfg_valid = 1'b0; cfg_start = 8'd0; cfg_stop = 8'd0; cfg_step = 8'd0;
    cfg_dwell = 16'd0; cfg_loop = 1'b0; pause = 1'b0; abort = 1'b0;

    // Reset state
    cyc(); cyc();
    chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", {24'd0, sweep_cnt}, 32'd0);
    chk("reset.ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0; #1;
    chk("idle.ready", {31'd0, cfg_ready}, 32'd1);

    // Basic sweep 10..40 step 10, dwell 3
    set_cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
    cyc(); cfg_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
        chk_out("basic", words[w], 1'b1, 1'b1, 1'b0);
        cyc();
      end
    end
    chk_out("basic.done", 8'd40, 1'b0, 1'b0, 1'b1);
    chk("basic.cnt", {24'd0, sweep_cnt}, 32'd1);
    cyc();
    chk_out("basic.after", 8'd40, 1'b0, 1'b0, 1'b0);

    // Overflow clamp, accepted in DONE with counter restart
    set_cfg(8'd250, 8'd255, 8'd4, 16'd1, 1'b0);
    cyc(); cfg_valid = 1'b0;
    chk_out("ovf.w0", 8'd250, 1'b1, 1'b1, 1'b0);
    chk("ovf.cnt0", {24'd0, sweep_cnt}, 32'd0);
    cyc();
    chk_out("ovf.w1", 8'd254, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("ovf.done", 8'd254, 1'b0, 1'b0, 1'b1);
    chk("ovf.cnt1", {24'd0, sweep_cnt}, 32'd1);

    // start > stop emits only start
    set_cfg(8'd200, 8'd100, 8'd1, 16'd1, 1'b0);
    cyc(); cfg_valid = 1'b0;
    chk_out("rev.w0", 8'd200, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("rev.done", 8'd200, 1'b0, 1'b0, 1'b1);

    // dwell 0 behaves as 1
    set_cfg(8'd5, 8'd6, 8'd1, 16'd0, 1'b0);
    cyc(); cfg_valid = 1'b0;
    chk_out("dw0.w0", 8'd5, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("dw0.w1", 8'd6, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("dw0.done", 8'd6, 1'b0, 1'b0, 1'b1);

    // Loop mode and counter wrap
    set_cfg(8'd0, 8'd2, 8'd1, 16'd2, 1'b1);
    cyc(); cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_out("loop.seq", lseq[i], 1'b1, 1'b1, 1'b0);
      cyc();
    end
    chk_out("loop.wrap", 8'd0, 1'b1, 1'b1, 1'b0);
    chk("loop.cnt1", {24'd0, sweep_cnt}, 32'd1);
    repeat (1524) cyc();
    chk("loop.cnt255", {24'd0, sweep_cnt}, 32'd255);
    repeat (6) cyc();
    chk("loop.cnt256", {24'd0, sweep_cnt}, 32'd0);
    chk_out("loop.w256", 8'd0, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    cyc(); abort = 1'b0;
    chk_out("loop.abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Pause during 2nd cycle of a dwell-4 word, then at dwell expiry
    set_cfg(8'd10, 8'd30, 8'd10, 16'd4, 1'b0);
    cyc(); cfg_valid = 1'b0;
    chk_out("pause.c1", 8'd10, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("pause.c2", 8'd10, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out("pause.hold", 8'd10, 1'b0, 1'b1, 1'b0);
    end
    pause = 1'b0;
    cyc();
    chk_out("pause.c3", 8'd10, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("pause.c4", 8'd10, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("pause.next", 8'd20, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc();
    chk_out("pexp.last", 8'd20, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    cyc(); pause = 1'b0;
    chk_out("pexp.hold", 8'd20, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_out("pexp.resume", 8'd30, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc();
    chk_out("pexp.w30", 8'd30, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("pexp.done", 8'd30, 1'b0, 1'b0, 1'b1);
    chk("pexp.cnt", {24'd0, sweep_cnt}, 32'd1);

    // Abort during word 20, then abort blocks a config in IDLE
    set_cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
    cyc(); cfg_valid = 1'b0;
    repeat (3) cyc();
    chk_out("abort.w20", 8'd20, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    cyc();
    chk_out("abort.idle", 8'd20, 1'b0, 1'b0, 1'b0);
    chk("abort.cnt", {24'd0, sweep_cnt}, 32'd0);
    set_cfg(8'd99, 8'd120, 8'd1, 16'd1, 1'b0); #1;
    chk("abort.ready", {31'd0, cfg_ready}, 32'd0);
    cyc();
    chk_out("abort.nostart", 8'd20, 1'b0, 1'b0, 1'b0);
    abort = 1'b0; cfg_valid = 1'b0; #1;
    chk("abort.ready1", {31'd0, cfg_ready}, 32'd1);

    // New config after abort; cfg_valid while busy is ignored
    set_cfg(8'd7, 8'd9, 8'd1, 16'd2, 1'b0);
    cyc();
    chk_out("restart.w7", 8'd7, 1'b1, 1'b1, 1'b0);
    set_cfg(8'd100, 8'd120, 8'd1, 16'd1, 1'b0); #1;
    chk("busy.ready", {31'd0, cfg_ready}, 32'd0);
    cyc(); cfg_valid = 1'b0;
    chk_out("busy.w7", 8'd7, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("busy.w8", 8'd8, 1'b1, 1'b1, 1'b0);

    // Reset mid-sweep
    rst = 1'b1;
    cyc();
    chk_out("rstmid", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("rstmid.cnt", {24'd0, sweep_cnt}, 32'd0);
    chk("rstmid.ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0;
    cyc();
    chk_out("rstmid.idle", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
